// File: rtl/spike_decoder_pkg.sv
// Shared types and helpers for the spike rate decoder: FSM state encoding,
// default counter width and the saturating increment used by both counters.
package spike_decoder_pkg;

  localparam int COUNT_W_DEF = 8;

  localparam logic [0:0] IDLE_ENC  = 1'b0;
  localparam logic [0:0] COUNT_ENC = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = IDLE_ENC,
    COUNT = COUNT_ENC
  } state_e;

  // Adds inc to val but never exceeds 2^width-1; width is expected to be < 32.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic        inc,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    if (inc && (val < max_val)) return val + 32'd1;
    return val;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Bundle between a spike source / host and the spike rate decoder.
interface spike_rate_decoder_if #(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = 8
) ();

  // Handshake: no back-pressure. en/spike/window_len are sampled every rising
  // edge; rate_valid and isi_valid are single-cycle strobes that mark the cycle
  // in which rate/isi take a new value, and must be consumed in that cycle.
  logic                en;
  logic                spike;
  logic [WINDOW_W-1:0] window_len;
  logic [COUNT_W-1:0]  rate;
  logic                rate_valid;
  logic [COUNT_W-1:0]  isi;
  logic                isi_valid;

  modport master (
    output en, spike, window_len,
    input  rate, rate_valid, isi, isi_valid
  );

  modport slave (
    input  en, spike, window_len,
    output rate, rate_valid, isi, isi_valid
  );

endinterface

// File: rtl/spike_isi_timer.sv
// Inter-spike interval timer: counts cycles since the last spike and reports
// the interval on every spike after the first one since enable.
module spike_isi_timer
  import spike_decoder_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               spike,
  output logic [COUNT_W-1:0] isi,
  output logic               isi_valid
);

  logic [COUNT_W-1:0] int_cnt_q;
  logic               armed_q;
  logic [COUNT_W-1:0] isi_q;
  logic               isi_valid_q;

  // The counter restarts at 1 on a spike so back-to-back spikes report 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_cnt_q   <= '0;
      armed_q     <= 1'b0;
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
    end else begin
      isi_valid_q <= 1'b0;
      if (!en) begin
        armed_q   <= 1'b0;
        int_cnt_q <= '0;
      end else if (spike) begin
        if (armed_q) begin
          isi_q       <= int_cnt_q;
          isi_valid_q <= 1'b1;
        end
        armed_q   <= 1'b1;
        int_cnt_q <= COUNT_W'(1);
      end else begin
        int_cnt_q <= COUNT_W'(sat_inc(32'(int_cnt_q), 1'b1, COUNT_W));
      end
    end
  end

  assign isi       = isi_q;
  assign isi_valid = isi_valid_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: windowed firing-rate counter plus an optional ISI timer
// (compiled in with SPIKE_RATE_DECODER_ISI_EN).
module spike_rate_decoder
  import spike_decoder_pkg::*;
#(
  parameter int WINDOW_W = 8,
  parameter int COUNT_W  = COUNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  spike_rate_decoder_if.slave bus,
  output logic [0:0] state_dbg
);

  state_e              state_q;
  logic [WINDOW_W-1:0] win_cnt_q;
  logic [COUNT_W-1:0]  spike_cnt_q;
  logic [COUNT_W-1:0]  rate_q;
  logic                rate_valid_q;
  logic [COUNT_W-1:0]  cnt_next;

  assign cnt_next = COUNT_W'(sat_inc(32'(spike_cnt_q), bus.spike, COUNT_W));

  // win_cnt_q holds remaining cycles minus one, so window_len=0 wraps to the
  // full 2^WINDOW_W window without an extra counter bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      spike_cnt_q  <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      if (!bus.en) begin
        state_q     <= IDLE;
        win_cnt_q   <= '0;
        spike_cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= COUNT;
            win_cnt_q   <= bus.window_len - WINDOW_W'(1);
            spike_cnt_q <= '0;
          end
          COUNT: begin
            if (win_cnt_q == '0) begin
              rate_q       <= cnt_next;
              rate_valid_q <= 1'b1;
              spike_cnt_q  <= COUNT_W'(bus.spike);
              win_cnt_q    <= bus.window_len - WINDOW_W'(1);
            end else begin
              win_cnt_q   <= win_cnt_q - WINDOW_W'(1);
              spike_cnt_q <= cnt_next;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign state_dbg      = state_q;

`ifdef SPIKE_RATE_DECODER_ISI_EN
  spike_isi_timer #(
    .COUNT_W (COUNT_W)
  ) u_isi (
    .clk       (clk),
    .rst       (rst),
    .en        (bus.en),
    .spike     (bus.spike),
    .isi       (bus.isi),
    .isi_valid (bus.isi_valid)
  );
`else
  assign bus.isi       = '0;
  assign bus.isi_valid = 1'b0;
`endif

endmodule
